// File: rtl/clock_pkg.sv
// Shared time-of-day widths, limits and the alarm ring-state encoding.
package clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } ring_state_e;

endpackage : clock_pkg

// File: rtl/alarm_unit_if.sv
// Command pulses, running time and alarm outputs exchanged with the alarm unit.
interface alarm_unit_if;
  import clock_pkg::*;

  logic              ALM_ONOFF;
  logic              ALM_HOUR;
  logic              ALM_MIN;
  logic              SEC_TICK;
  logic [HOUR_W-1:0] CUR_HOUR;
  logic [MIN_W-1:0]  CUR_MIN;
  logic [SEC_W-1:0]  CUR_SEC;
  logic              SW_STOP;
  logic              SW_SNOOZE;
  logic              ALM_EN;
  logic [HOUR_W-1:0] ALM_H;
  logic [MIN_W-1:0]  ALM_M;
  logic              RING;

  modport master (
    output ALM_ONOFF, ALM_HOUR, ALM_MIN, SEC_TICK,
    output CUR_HOUR, CUR_MIN, CUR_SEC, SW_STOP, SW_SNOOZE,
    input  ALM_EN, ALM_H, ALM_M, RING
  );

  modport slave (
    input  ALM_ONOFF, ALM_HOUR, ALM_MIN, SEC_TICK,
    input  CUR_HOUR, CUR_MIN, CUR_SEC, SW_STOP, SW_SNOOZE,
    output ALM_EN, ALM_H, ALM_M, RING
  );

endinterface : alarm_unit_if

// File: rtl/mod_counter.sv
// Modulo-N up counter: advances on inc, wraps from MODULUS-1 back to zero.
module mod_counter #(
  parameter int MODULUS = 24,
  parameter int W       = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value_q
);

  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc) begin
      if (value_q == W'(MODULUS - 1)) begin
        value_d = {W{1'b0}};
      end else begin
        value_d = value_q + W'(1);
      end
    end else begin
      value_d = value_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= {W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

endmodule : mod_counter

// File: rtl/alarm_unit.sv
// Alarm time/enable storage, alarm-time comparator and ring/snooze sequencer
// driving the buzzer enable.
module alarm_unit
  import clock_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic         clock,
  input  logic         reset,
  alarm_unit_if.slave  bus
);

  localparam int MAX_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CNT_W   = (MAX_SEC > 1) ? $clog2(MAX_SEC) : 1;

  ring_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ring_q, ring_d;
  logic             alm_en_q, alm_en_d;
  logic             match_q, match_prev_q;
  logic             match_s, rise_s, en_clear_s;
  logic [HOUR_W-1:0] alm_h_s;
  logic [MIN_W-1:0]  alm_m_s;

  mod_counter #(.MODULUS(HOUR_MAX + 1), .W(HOUR_W)) u_hour (
    .clock   (clock),
    .reset   (reset),
    .inc     (bus.ALM_HOUR),
    .value_q (alm_h_s)
  );

  mod_counter #(.MODULUS(MIN_MAX + 1), .W(MIN_W)) u_min (
    .clock   (clock),
    .reset   (reset),
    .inc     (bus.ALM_MIN),
    .value_q (alm_m_s)
  );

  // Edge is taken between two registered copies so RING rises two clocks after the match.
  always_comb begin
    alm_en_d   = alm_en_q ^ bus.ALM_ONOFF;
    en_clear_s = bus.ALM_ONOFF & alm_en_q;
    match_s    = alm_en_q & (bus.CUR_HOUR == alm_h_s) & (bus.CUR_MIN == alm_m_s)
                 & (bus.CUR_SEC == {SEC_W{1'b0}});
    rise_s     = match_q & ~match_prev_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = RINGING;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RINGING: begin
        if (en_clear_s || bus.SW_STOP) begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (bus.SW_SNOOZE) begin
          state_d = SNOOZE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (bus.SEC_TICK) begin
          if (cnt_q == CNT_W'(RING_SEC - 1)) begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = RINGING;
        end
      end
      SNOOZE: begin
        if (en_clear_s || bus.SW_STOP) begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (bus.SEC_TICK) begin
          if (cnt_q == CNT_W'(SNOOZE_SEC - 1)) begin
            state_d = RINGING;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = SNOOZE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    ring_d = (state_d == RINGING);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      ring_q       <= 1'b0;
      alm_en_q     <= 1'b0;
      match_q      <= 1'b0;
      match_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ring_q       <= ring_d;
      alm_en_q     <= alm_en_d;
      match_q      <= match_s;
      match_prev_q <= match_q;
    end
  end

  assign bus.ALM_EN = alm_en_q;
  assign bus.ALM_H  = alm_h_s;
  assign bus.ALM_M  = alm_m_s;
  assign bus.RING   = ring_q;

endmodule : alarm_unit

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: alarm-time editing, match/ring timing,
// ring duration, snooze, stop, enable clear and asynchronous reset.
module tb_alarm_unit;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  alarm_unit_if u_if ();

  alarm_unit #(.RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // sel: 0 onoff, 1 hour, 2 min, 3 tick, 4 stop, 5 snooze, 6 hour+min, 7 stop+snooze
  task automatic pulse(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      case (sel)
        0: u_if.ALM_ONOFF = 1'b1;
        1: u_if.ALM_HOUR  = 1'b1;
        2: u_if.ALM_MIN   = 1'b1;
        3: u_if.SEC_TICK  = 1'b1;
        4: u_if.SW_STOP   = 1'b1;
        5: u_if.SW_SNOOZE = 1'b1;
        6: begin u_if.ALM_HOUR = 1'b1; u_if.ALM_MIN = 1'b1; end
        7: begin u_if.SW_STOP = 1'b1; u_if.SW_SNOOZE = 1'b1; end
        default: ;
      endcase
      @(negedge clock);
      u_if.ALM_ONOFF = 1'b0;
      u_if.ALM_HOUR  = 1'b0;
      u_if.ALM_MIN   = 1'b0;
      u_if.SEC_TICK  = 1'b0;
      u_if.SW_STOP   = 1'b0;
      u_if.SW_SNOOZE = 1'b0;
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    @(negedge clock);
    u_if.CUR_HOUR = 5'(h);
    u_if.CUR_MIN  = 6'(m);
    u_if.CUR_SEC  = 6'(s);
  endtask

  // Drop the match for a moment, then present hh:mm:00 and wait the two-clock latency.
  task automatic trigger(input int h, input int m);
    set_time(h, m, 1);
    repeat (2) @(negedge clock);
    set_time(h, m, 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset          = 1'b0;
    u_if.ALM_ONOFF = 1'b0;
    u_if.ALM_HOUR  = 1'b0;
    u_if.ALM_MIN   = 1'b0;
    u_if.SEC_TICK  = 1'b0;
    u_if.SW_STOP   = 1'b0;
    u_if.SW_SNOOZE = 1'b0;
    u_if.CUR_HOUR  = 5'd0;
    u_if.CUR_MIN   = 6'd0;
    u_if.CUR_SEC   = 6'd5;
    repeat (3) @(negedge clock);
    check_eq("rst_en", 32'(u_if.ALM_EN), 32'd0);
    check_eq("rst_h", 32'(u_if.ALM_H), 32'd0);
    check_eq("rst_m", 32'(u_if.ALM_M), 32'd0);
    check_eq("rst_ring", 32'(u_if.RING), 32'd0);
    reset = 1'b1;

    pulse(1, 3);
    pulse(2, 2);
    check_eq("h_3", 32'(u_if.ALM_H), 32'd3);
    check_eq("m_2", 32'(u_if.ALM_M), 32'd2);
    check_eq("en_0", 32'(u_if.ALM_EN), 32'd0);

    pulse(1, 20);
    check_eq("h_23", 32'(u_if.ALM_H), 32'd23);
    pulse(1, 1);
    check_eq("h_wrap", 32'(u_if.ALM_H), 32'd0);
    pulse(2, 57);
    check_eq("m_59", 32'(u_if.ALM_M), 32'd59);
    pulse(2, 1);
    check_eq("m_wrap", 32'(u_if.ALM_M), 32'd0);
    check_eq("m_nocarry", 32'(u_if.ALM_H), 32'd0);

    pulse(6, 1);
    check_eq("both_h", 32'(u_if.ALM_H), 32'd1);
    check_eq("both_m", 32'(u_if.ALM_M), 32'd1);
    pulse(1, 6);
    pulse(2, 29);
    check_eq("set_h7", 32'(u_if.ALM_H), 32'd7);
    check_eq("set_m30", 32'(u_if.ALM_M), 32'd30);

    // Disabled: matching time must not ring
    set_time(7, 29, 59);
    repeat (2) @(negedge clock);
    set_time(7, 30, 0);
    repeat (4) @(negedge clock);
    check_eq("dis_ring", 32'(u_if.RING), 32'd0);

    set_time(7, 29, 59);
    pulse(0, 1);
    check_eq("en_1", 32'(u_if.ALM_EN), 32'd1);
    repeat (2) @(negedge clock);
    u_if.CUR_MIN = 6'd30;
    u_if.CUR_SEC = 6'd0;
    @(negedge clock);
    check_eq("ring_lat1", 32'(u_if.RING), 32'd0);
    @(negedge clock);
    check_eq("ring_lat2", 32'(u_if.RING), 32'd1);

    pulse(3, RING_SEC - 1);
    check_eq("ring_hold", 32'(u_if.RING), 32'd1);
    pulse(3, 1);
    check_eq("ring_auto_off", 32'(u_if.RING), 32'd0);
    pulse(3, 3);
    check_eq("no_rering", 32'(u_if.RING), 32'd0);

    trigger(7, 30);
    check_eq("ring2", 32'(u_if.RING), 32'd1);
    pulse(5, 1);
    check_eq("snooze_off", 32'(u_if.RING), 32'd0);
    pulse(2, 1);
    check_eq("edit_m31", 32'(u_if.ALM_M), 32'd31);
    pulse(3, SNOOZE_SEC - 1);
    check_eq("snooze_hold", 32'(u_if.RING), 32'd0);
    pulse(3, 1);
    check_eq("snooze_rering", 32'(u_if.RING), 32'd1);
    pulse(7, 1);
    check_eq("stop_prio", 32'(u_if.RING), 32'd0);
    pulse(3, SNOOZE_SEC + 2);
    check_eq("stop_idle", 32'(u_if.RING), 32'd0);

    trigger(7, 31);
    check_eq("ring3", 32'(u_if.RING), 32'd1);
    pulse(0, 1);
    check_eq("clr_en", 32'(u_if.ALM_EN), 32'd0);
    check_eq("clr_ring", 32'(u_if.RING), 32'd0);

    pulse(0, 1);
    trigger(7, 31);
    check_eq("ring4", 32'(u_if.RING), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_ring", 32'(u_if.RING), 32'd0);
    check_eq("arst_en", 32'(u_if.ALM_EN), 32'd0);
    check_eq("arst_h", 32'(u_if.ALM_H), 32'd0);
    check_eq("arst_m", 32'(u_if.ALM_M), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alarm_unit
